// File: rtl/switching_stage_pipe.sv
// switching_stage_pipe: two-stage detect/switch pipeline of the switching median filter
//
// Takes an N-pixel window and its median MV. Pixels outside the noise band
// (<= Noise_Lo or >= Noise_Hi) are replaced by MV, and clean pixels pass unchanged.
// Mode selects switch (0/3), bypass (1) or full median (2).
//
// Optional feature macro: SWS_STATS_EN. When it is defined, Noise_Total counts
// replaced pixels and saturates at the top of its range. When it is undefined,
// Noise_Total is tied to 0 and Stat_Clr is ignored.
//
// Ports
//   Clk, Rst            rising-edge clock, asynchronous active-high reset
//   In_Valid/In_Ready   input handshake for Win, MV, Noise_Lo, Noise_Hi, Mode
//   Win                 N*WIDTH window, pixel i = Win[i*WIDTH +: WIDTH]
//   MV                  median of the window
//   Noise_Lo/Noise_Hi   inclusive noise thresholds
//   Mode                0 switch, 1 bypass, 2 full median, 3 switch
//   Out_Valid/Out_Ready output handshake
//   New_Win             processed window, same packing as Win
//   Noise_Mask          per-pixel noise flags
//   All_Noise           every pixel of the window was noisy
//   Stat_Clr            synchronous clear of Noise_Total
//   Noise_Total         replaced-pixel count
module switching_stage_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 9,
    parameter int CNT_W = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [N*WIDTH-1:0] Win,
    input  logic [WIDTH-1:0]   MV,
    input  logic [WIDTH-1:0]   Noise_Lo,
    input  logic [WIDTH-1:0]   Noise_Hi,
    input  logic [1:0]         Mode,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [N*WIDTH-1:0] New_Win,
    output logic [N-1:0]       Noise_Mask,
    output logic               All_Noise,
    input  logic               Stat_Clr,
    output logic [CNT_W-1:0]   Noise_Total
);
    logic               ready_s1, ready_s2, ld_s1, ld_s2;
    logic               s1_v;
    logic [N*WIDTH-1:0] s1_win;
    logic [WIDTH-1:0]   s1_mv;
    logic [1:0]         s1_mode;
    logic [N-1:0]       s1_mask, det_mask;
    logic [N*WIDTH-1:0] sw_win;

    // A stage can load when it is empty or when its content leaves this cycle.
    assign ready_s2 = !Out_Valid || Out_Ready;
    assign ready_s1 = !s1_v || ready_s2;
    assign In_Ready = ready_s1;
    assign ld_s1    = In_Valid && ready_s1;
    assign ld_s2    = s1_v && ready_s2;

    // An empty band (Lo >= Hi) flags every pixel, with no special case needed.
    for (genvar i = 0; i < N; i++) begin : g_pix
        assign det_mask[i] = (Win[i*WIDTH +: WIDTH] <= Noise_Lo) ||
                             (Win[i*WIDTH +: WIDTH] >= Noise_Hi);
        assign sw_win[i*WIDTH +: WIDTH] =
            (s1_mode == 2'd1) ? s1_win[i*WIDTH +: WIDTH] :
            (s1_mode == 2'd2) ? s1_mv :
            s1_mask[i]        ? s1_mv : s1_win[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_v    <= 1'b0;
            s1_win  <= '0;
            s1_mv   <= '0;
            s1_mode <= '0;
            s1_mask <= '0;
        end else begin
            if (ready_s1) s1_v <= In_Valid;
            if (ld_s1) begin
                s1_win  <= Win;
                s1_mv   <= MV;
                s1_mode <= Mode;
                s1_mask <= det_mask;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out_Valid  <= 1'b0;
            New_Win    <= '0;
            Noise_Mask <= '0;
            All_Noise  <= 1'b0;
        end else begin
            if (ready_s2) Out_Valid <= s1_v;
            if (ld_s2) begin
                New_Win    <= sw_win;
                Noise_Mask <= s1_mask;
                All_Noise  <= &s1_mask;
            end
        end
    end

`ifdef SWS_STATS_EN
    localparam int PC_W = $clog2(N + 1);
    localparam int SW   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0] pop, add;
    logic [SW-1:0]   sum;
    logic [CNT_W-1:0] nxt_total;

    always_comb begin
        pop = '0;
        for (int k = 0; k < N; k++) pop = pop + PC_W'(s1_mask[k]);
        add = (s1_mode == 2'd1 || s1_mode == 2'd2) ? '0 : pop;
        // Clearing on a load restarts the count from the new window's contribution.
        sum = (Stat_Clr ? '0 : SW'(Noise_Total)) + SW'(add);
        nxt_total = (sum > SW'(MAX)) ? MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Noise_Total <= '0;
        else if (ld_s2) Noise_Total <= nxt_total;
        else if (Stat_Clr) Noise_Total <= '0;
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = Stat_Clr;
    assign Noise_Total     = '0;
`endif
endmodule

// File: tb/tb_switching_stage_pipe.sv
// tb_switching_stage_pipe: directed vector bench for switching_stage_pipe
module tb_switching_stage_pipe;
    localparam int W  = 8;
    localparam int N  = 9;
    localparam int CW = 4;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           In_Valid, In_Ready, Out_Valid, Out_Ready, All_Noise, Stat_Clr;
    logic [N*W-1:0] Win, New_Win;
    logic [W-1:0]   MV, Noise_Lo, Noise_Hi;
    logic [1:0]     Mode;
    logic [N-1:0]   Noise_Mask;
    logic [CW-1:0]  Noise_Total;

    switching_stage_pipe #(.WIDTH(W), .N(N), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready), .Win(Win),
        .MV(MV), .Noise_Lo(Noise_Lo), .Noise_Hi(Noise_Hi), .Mode(Mode),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .New_Win(New_Win),
        .Noise_Mask(Noise_Mask), .All_Noise(All_Noise), .Stat_Clr(Stat_Clr),
        .Noise_Total(Noise_Total)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    endfunction

    function automatic logic [71:0] rep(input int v);
        return pk(v, v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [71:0] bp_win(input int j);
        int v = 10 * (j + 1);
        return pk(0, v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [71:0] bp_exp(input int j);
        int v = 10 * (j + 1);
        return pk(100 + j, v, v, v, v, v, v, v, v);
    endfunction

    typedef struct {
        logic [71:0] win;
        logic [7:0]  mv, lo, hi;
        logic [1:0]  mode;
        logic [71:0] ew;
        logic [8:0]  em;
        logic        ea;
    } vec_t;

    vec_t vt[8];

    task automatic send_one(input logic [71:0] w, input int mv, input int lo, input int hi, input int md);
        In_Valid = 1'b1; Win = w; MV = 8'(mv); Noise_Lo = 8'(lo); Noise_Hi = 8'(hi); Mode = 2'(md);
        @(posedge Clk); #1;
        In_Valid = 1'b0; Win = ~w; MV = 8'hEE; Noise_Lo = 8'd200; Noise_Hi = 8'd100; Mode = 2'd2;
    endtask

    initial begin
        logic [71:0] w0, prev;
        int sent, rcv, cyc;
        logic seen;
        w0 = pk(0, 10, 20, 255, 40, 50, 60, 70, 80);
        vt[0] = '{w0, 45, 0, 255, 0, pk(45, 10, 20, 45, 40, 50, 60, 70, 80), 9'b000001001, 1'b0};
        vt[1] = '{w0, 45, 0, 255, 1, w0, 9'b000001001, 1'b0};
        vt[2] = '{w0, 45, 0, 255, 2, rep(45), 9'b000001001, 1'b0};
        vt[3] = '{w0, 45, 0, 255, 3, pk(45, 10, 20, 45, 40, 50, 60, 70, 80), 9'b000001001, 1'b0};
        vt[4] = '{pk(0, 255, 0, 255, 0, 255, 0, 255, 0), 7, 0, 255, 0, rep(7), 9'h1FF, 1'b1};
        vt[5] = '{pk(10, 16, 239, 240, 100, 100, 100, 100, 100), 50, 15, 240, 0,
                  pk(50, 16, 239, 50, 100, 100, 100, 100, 100), 9'b000001001, 1'b0};
        vt[6] = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 5, 200, 100, 0, rep(5), 9'h1FF, 1'b1};
        vt[7] = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 99, 0, 255, 0, pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 9'h000, 1'b0};

        Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1; Stat_Clr = 1'b0;
        Win = '0; MV = '0; Noise_Lo = '0; Noise_Hi = 8'd255; Mode = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_new_win", New_Win, 0);
        chk("rst_mask", Noise_Mask, 0);
        chk("rst_all_noise", All_Noise, 0);
        chk("rst_total", Noise_Total, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("rst_in_ready", In_Ready, 1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_in_ready", i), In_Ready, 1);
            send_one(vt[i].win, vt[i].mv, vt[i].lo, vt[i].hi, vt[i].mode);
            chk($sformatf("v%0d_lat1", i), Out_Valid, 0);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_valid", i), Out_Valid, 1);
            chk($sformatf("v%0d_win", i), New_Win, vt[i].ew);
            chk($sformatf("v%0d_mask", i), Noise_Mask, vt[i].em);
            chk($sformatf("v%0d_all", i), All_Noise, vt[i].ea);
        end
        @(posedge Clk); #1;
        chk("drain_valid", Out_Valid, 0);

        sent = 0; rcv = 0; prev = '0;
        Noise_Lo = 8'd0; Noise_Hi = 8'd255; Mode = 2'd0;
        for (cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            In_Valid = (sent < 5); Win = bp_win(sent); MV = 8'(100 + sent);
            Out_Ready = (cyc >= 6);
            @(negedge Clk);
            if (cyc == 2) begin
                chk("bp_first_valid", Out_Valid, 1);
                chk("bp_first_win", New_Win, bp_exp(0));
            end
            if (cyc >= 2 && cyc < 6) chk($sformatf("bp_in_ready_low_c%0d", cyc), In_Ready, 0);
            if (cyc > 2 && cyc < 6) chk($sformatf("bp_hold_c%0d", cyc), New_Win, prev);
            if (cyc == 5) chk("bp_accepted", sent, 2);
            prev = New_Win;
            if (In_Valid && In_Ready) sent++;
            if (Out_Valid && Out_Ready) begin
                chk($sformatf("bp_order_%0d", rcv), New_Win, bp_exp(rcv));
                rcv++;
            end
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        chk("bp_count", rcv, 5);
        @(negedge Clk);
        chk("bp_no_dup", Out_Valid, 0);
        @(posedge Clk); #1;

        Out_Ready = 1'b0;
        send_one(bp_win(0), 100, 0, 255, 0);
        send_one(bp_win(1), 101, 0, 255, 0);
        #2;
        Rst = 1'b1;
        #1;
        chk("midrst_valid", Out_Valid, 0);
        chk("midrst_win", New_Win, 0);
        chk("midrst_mask", Noise_Mask, 0);
        chk("midrst_all", All_Noise, 0);
        @(posedge Clk); #1;
        Rst = 1'b0; Out_Ready = 1'b1;
        chk("midrst_in_ready", In_Ready, 1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            seen = seen | Out_Valid;
        end
        chk("midrst_dropped", seen, 0);
        @(posedge Clk); #1;

`ifdef SWS_STATS_EN
        Stat_Clr = 1'b1;
        @(posedge Clk); #1;
        Stat_Clr = 1'b0;
        chk("stat_clr_idle", Noise_Total, 0);
        for (int k = 0; k < 8; k++) begin
            send_one(pk(0, 255, 50, 50, 50, 50, 50, 50, 50), 50, 0, 255, 0);
            @(posedge Clk); #1;
            chk($sformatf("stat_cnt_%0d", k), Noise_Total, (2 * (k + 1) > 15) ? 15 : 2 * (k + 1));
        end
        send_one(pk(0, 255, 50, 50, 50, 50, 50, 50, 50), 50, 0, 255, 0);
        Stat_Clr = 1'b1;
        @(posedge Clk); #1;
        Stat_Clr = 1'b0;
        chk("stat_clr_load", Noise_Total, 2);
        send_one(pk(0, 255, 50, 50, 50, 50, 50, 50, 50), 50, 0, 255, 1);
        @(posedge Clk); #1;
        chk("stat_bypass_adds0", Noise_Total, 2);
`else
        Stat_Clr = 1'b1;
        send_one(pk(0, 255, 50, 50, 50, 50, 50, 50, 50), 50, 0, 255, 0);
        @(posedge Clk); #1;
        Stat_Clr = 1'b0;
        chk("stat_tied_zero", Noise_Total, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
